// File: rtl/hex_display_bank.sv
// ============================================================================
// Module  : hex_display_bank
// Purpose : Parallel 0-F seven-segment driver with leading-zero and blink blanking.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module hex_display_bank #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic                  lz_blank,
  output logic [7*DIGITS-1:0]   display
);

  localparam int               CNT_W     = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  logic [4*DIGITS-1:0] val_q,       val_d;
  logic [CNT_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                blink_off_q, blink_off_d;
  logic [7*DIGITS-1:0] display_q,   display_d;
  logic                w_cnt_wrap;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  always_comb begin
    w_cnt_wrap  = (blink_cnt_q == CNT_MAX);
    blink_cnt_d = w_cnt_wrap ? '0 : blink_cnt_q + CNT_W'(1);
    blink_off_d = blink_off_q ^ w_cnt_wrap;
    val_d       = load ? value : val_q;
  end

  // Scan from the most significant digit; once a nonzero nibble is seen,
  // every lower digit is significant and shown.
  always_comb begin
    logic       nz_seen;
    logic [3:0] nib;
    logic [6:0] seg;
    nz_seen   = 1'b0;
    nib       = 4'h0;
    seg       = SEG_BLANK;
    display_d = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = val_q[4*i +: 4];
      if (nib != 4'h0) nz_seen = 1'b1;
      if (blink_off_q && blink_en[i])
        seg = SEG_BLANK;
      else if (lz_blank && !nz_seen && (i != 0))
        seg = SEG_BLANK;
      else
        seg = seg_decode(nib);
      display_d[7*i +: 7] = seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q       <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      display_q   <= '1;
    end else begin
      val_q       <= val_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      display_q   <= display_d;
    end
  end

  assign display = display_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_bank.sv
// ============================================================================
// Module  : tb_hex_display_bank
// Purpose : Directed self-checking bench for hex_display_bank (DIGITS=4, BLINK_DIV=4).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_hex_display_bank;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blink_en;
  logic        lz_blank;
  logic [27:0] display;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] BL = 7'b1111111;

  hex_display_bank #(.DIGITS(4), .BLINK_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .blink_en (blink_en),
    .lz_blank (lz_blank),
    .display  (display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; blink_en = '0; lz_blank = 1'b0;

    // Reset and release
    edges(2);
    check("reset_dark", display, 28'hFFFFFFF);
    rst_n = 1'b1;
    edges(2);
    check("post_reset_zeros", display, {seg(0), seg(0), seg(0), seg(0)});

    // Plain load, two-edge latency, hold
    load = 1'b1; value = 16'h1A3F;
    edges(1);
    load = 1'b0;
    check("load_latency_old", display, {seg(0), seg(0), seg(0), seg(0)});
    edges(1);
    check("load_1A3F", display, {seg(1), seg(4'hA), seg(3), seg(4'hF)});
    edges(3);
    check("hold_1A3F", display, {seg(1), seg(4'hA), seg(3), seg(4'hF)});

    // Leading-zero blanking
    lz_blank = 1'b1; load = 1'b1; value = 16'h0050;
    edges(1); load = 1'b0; edges(1);
    check("lz_0050", display, {BL, BL, seg(5), seg(0)});
    load = 1'b1; value = 16'h0000;
    edges(1); load = 1'b0; edges(1);
    check("lz_0000", display, {BL, BL, BL, seg(0)});
    load = 1'b1; value = 16'h0203;
    edges(1); load = 1'b0; edges(1);
    check("lz_0203", display, {BL, seg(2), seg(0), seg(3)});

    // Blink on digit 0, from a fresh reset so the phase is known
    rst_n = 1'b0; edges(1); rst_n = 1'b1;
    lz_blank = 1'b0; blink_en = 4'b0001; load = 1'b1; value = 16'h1234;
    edges(1); load = 1'b0;                 // R1
    edges(3);                              // R4: toggle edge, still visible
    check("blink_vis_R4", display, {seg(1), seg(2), seg(3), seg(4)});
    edges(1);                              // R5
    check("blink_off_R5", display, {seg(1), seg(2), seg(3), BL});
    edges(3);                              // R8
    check("blink_off_R8", display, {seg(1), seg(2), seg(3), BL});
    edges(1);                              // R9
    check("blink_on_R9", display, {seg(1), seg(2), seg(3), seg(4)});
    edges(3);                              // R12
    check("blink_on_R12", display, {seg(1), seg(2), seg(3), seg(4)});
    edges(1);                              // R13
    check("blink_off_R13", display, {seg(1), seg(2), seg(3), BL});
    blink_en = 4'b0000;
    edges(1);                              // R14, blink_off still 1
    check("blink_disable", display, {seg(1), seg(2), seg(3), seg(4)});

    // Reset with load while blink_off=1
    blink_en = 4'b0001; rst_n = 1'b0; load = 1'b1; value = 16'hFFFF;
    edges(1);
    check("reset_over_load", display, 28'hFFFFFFF);
    rst_n = 1'b1; load = 1'b0;
    edges(1);                              // Q1
    check("reset_clears_val", display, {seg(0), seg(0), seg(0), seg(0)});
    edges(3);                              // Q4: first toggle, not yet visible
    check("reset_phase_Q4", display, {seg(0), seg(0), seg(0), seg(0)});
    edges(1);                              // Q5
    check("reset_phase_Q5", display, {seg(0), seg(0), seg(0), BL});

    // Streaming loads: digit 0 trails the value by two edges
    blink_en = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      load = 1'b1; value = 16'(i);
      edges(1);
      if (i >= 1)
        check($sformatf("stream_%0d", i - 1), {21'h0, display[6:0]}, {21'h0, seg(4'(i - 1))});
    end
    load = 1'b0;
    edges(1);
    check("stream_9", {21'h0, display[6:0]}, {21'h0, seg(4'h9)});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
